// File: rtl/d_flip_flop_pkg.sv
// Shared defaults for the d_flip_flop register slice.
// Only the structural defaults live here; the reset value is left to each instance.
package d_flip_flop_pkg;

    localparam int unsigned DFF_DEFAULT_WIDTH  = 1;
    localparam int unsigned DFF_DEFAULT_STAGES = 1;

endpackage

// File: rtl/d_flip_flop_if.sv
// Data link feeding one register stage: d into the stage, q out of it.
interface d_flip_flop_if #(
    parameter int unsigned WIDTH = 1
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (output d, input q);
    modport slave  (input d, output q);

endinterface

// File: rtl/d_flip_flop_dff_stage.sv
// One WIDTH-bit register stage with asynchronous, active-high clear to RESET_VALUE.
module dff_stage #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic        clk,
    input  logic        async_reset,
    d_flip_flop_if.slave bus
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    assign data_d = bus.d;

    // Reset dominates a coincident clock edge, so D is never captured while it is high.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign bus.q = data_q;

endmodule

// File: rtl/d_flip_flop.sv
// D-type register with asynchronous clear, cascaded STAGES deep as a delay line.
module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int unsigned      WIDTH       = DFF_DEFAULT_WIDTH,
    parameter int unsigned      STAGES      = DFF_DEFAULT_STAGES,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        d_flip_flop_if #(.WIDTH(WIDTH)) link ();

        // Stage 0 takes D; every later stage takes its predecessor's output.
        if (i == 0) begin : g_head
            assign link.d = D;
        end else begin : g_tail
            assign link.d = stage_q[i-1];
        end

        dff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk         (clk),
            .async_reset (async_reset),
            .bus         (link.slave)
        );

        assign stage_q[i] = link.q;
    end

    assign Q = stage_q[STAGES-1];

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: default 1-bit flop and an 8-bit, 3-deep delay line.
module tb_d_flip_flop;

    logic clk = 1'b0;
    logic rst1 = 1'b0;
    logic rst3 = 1'b1;

    int errors = 0;
    int checks = 0;

    d_flip_flop_if #(.WIDTH(1)) bus1 ();
    d_flip_flop_if #(.WIDTH(8)) bus3 ();

    d_flip_flop dut1 (
        .clk         (clk),
        .async_reset (rst1),
        .D           (bus1.d),
        .Q           (bus1.q)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .STAGES      (3),
        .RESET_VALUE (8'hA5)
    ) dut3 (
        .clk         (clk),
        .async_reset (rst3),
        .D           (bus3.d),
        .Q           (bus3.q)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic rst;
        logic d;
        logic exp_pre;
        logic exp_post;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // rst, d, Q 5 units after applying (before edge), Q 5 units after the edge
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0};

        bus1.d = 1'b0;
        bus3.d = 8'h00;

        for (int k = 0; k < 9; k++) begin
            rst1   = vecs[k].rst;
            bus1.d = vecs[k].d;
            #5;
            check($sformatf("vec%0d_pre", k), {7'b0, bus1.q}, {7'b0, vecs[k].exp_pre});
            @(posedge clk);
            #5;
            check($sformatf("vec%0d_post", k), {7'b0, bus1.q}, {7'b0, vecs[k].exp_post});
            @(negedge clk);
        end

        // Reset raised on the very same step as a rising edge: D=1 must not be captured.
        bus1.d = 1'b1;
        @(posedge clk);
        rst1 = 1'b1;
        #1;
        check("coincident_reset", {7'b0, bus1.q}, 8'h00);
        @(negedge clk);
        rst1 = 1'b0;
        #5;
        check("release_pre_edge", {7'b0, bus1.q}, 8'h00);
        @(posedge clk);
        #5;
        check("release_first_edge", {7'b0, bus1.q}, 8'h01);

        // D toggles between edges; Q only follows the value present at the edge.
        @(negedge clk);
        bus1.d = 1'b0; #2;
        check("hold_toggle_a", {7'b0, bus1.q}, 8'h01);
        bus1.d = 1'b1; #2;
        bus1.d = 1'b0; #2;
        check("hold_toggle_b", {7'b0, bus1.q}, 8'h01);
        bus1.d = 1'b1; #2;
        bus1.d = 1'b0;
        @(posedge clk);
        #1;
        check("hold_edge_sample", {7'b0, bus1.q}, 8'h00);
        bus1.d = 1'b1; #3;
        bus1.d = 1'b0; #3;
        bus1.d = 1'b1; #2;
        check("hold_after_edge", {7'b0, bus1.q}, 8'h00);
        @(posedge clk);
        #1;
        check("hold_next_edge", {7'b0, bus1.q}, 8'h01);

        // Delay line: reset value visible, then 3-edge latency, then mid-pipeline clear.
        @(negedge clk);
        check("dl_reset_value", bus3.q, 8'hA5);
        rst3   = 1'b0;
        bus3.d = 8'h3C;
        @(posedge clk); #1;
        bus3.d = 8'h11;
        check("dl_edge1", bus3.q, 8'hA5);
        @(posedge clk); #1;
        check("dl_edge2", bus3.q, 8'hA5);
        @(posedge clk); #1;
        check("dl_edge3", bus3.q, 8'h3C);
        @(posedge clk); #1;
        check("dl_edge4", bus3.q, 8'h11);
        bus3.d = 8'h5A;
        @(posedge clk); #1;
        check("dl_edge5", bus3.q, 8'h11);
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        check("dl_mid_clear", bus3.q, 8'hA5);
        @(posedge clk); #1;
        check("dl_clear_held", bus3.q, 8'hA5);
        @(negedge clk);
        rst3 = 1'b0;
        @(posedge clk); #1;
        check("dl_after_release", bus3.q, 8'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
